mon_pro_radix: RTL

MON_PRO_RADIX -- requirements
Module: mon_pro_radix

---
 rtl/mon_pro_radix_if.sv | 17 +
 rtl/mon_pro_radix.sv | 91 +++++++++
 2 files changed

// File: rtl/mon_pro_radix_if.sv
// Request/response bundle for the radix-2^p Montgomery multiplier.
interface mon_pro_radix_if #(
  parameter int WIDTH      = 64,
  parameter int RADIX_LOG2 = 2
);
  logic                  start;
  logic [WIDTH-1:0]      A;
  logic [WIDTH-1:0]      B;
  logic [WIDTH-1:0]      M;
  logic [RADIX_LOG2-1:0] M_INV;
  logic                  busy;
  logic                  done;
  logic [WIDTH:0]        P;

  modport master (output start, A, B, M, M_INV, input  busy, done, P);
  modport slave  (input  start, A, B, M, M_INV, output busy, done, P);
endinterface

// File: rtl/mon_pro_radix.sv
// Digit-serial Montgomery product P = A*B*R^-1 mod M, one radix-2^p digit of B per cycle.
module mon_pro_radix #(
  parameter int WIDTH      = 64,
  parameter int RADIX_LOG2 = 2,
  parameter int FINAL_SUB  = 1
) (
  input  logic          clk,
  input  logic          rst,
  mon_pro_radix_if.slave bus
);
  localparam int DW       = RADIX_LOG2;
  localparam int N_DIGITS = (WIDTH + DW - 1) / DW;
  localparam int BW       = N_DIGITS * DW;
  localparam int AW       = WIDTH + DW + 2;
  localparam int CW       = $clog2(N_DIGITS + 1);

  typedef enum logic {IDLE, CALC} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, m_q;
  logic [DW-1:0]    minv_q;
  logic [BW-1:0]    b_q;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH:0]   p_q, p_fin;

  logic [DW-1:0]    bt, q;
  logic [AW-1:0]    t, tq;

  // One Montgomery step: q makes (T + q*M) divisible by 2^p, so the shift is exact.
  always_comb begin
    bt    = b_q[DW-1:0];
    t     = acc_q + AW'(a_q) * AW'(bt);
    q     = t[DW-1:0] * minv_q;
    tq    = t + AW'(m_q) * AW'(q);
    acc_d = tq >> DW;
    p_fin = acc_q[WIDTH:0];
    if ((FINAL_SUB != 0) && (acc_q >= AW'(m_q)))
      p_fin = acc_q[WIDTH:0] - {1'b0, m_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      minv_q  <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            m_q     <= bus.M;
            minv_q  <= bus.M_INV;
            b_q     <= BW'(bus.B);
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          // After N_DIGITS steps the counter saturates and the next edge retires.
          if (cnt_q == CW'(N_DIGITS)) begin
            p_q     <= p_fin;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            b_q   <= b_q >> DW;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.P    = p_q;
endmodule
